// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared widths, control-bit positions and bubble constant for the
//          inter-stage pipeline registers.
// Rev    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_CTRL_W = 8;

    // Bit positions inside the control payload; any set bit has a side effect.
    typedef enum int unsigned {
        CTRL_REG_WRITE  = 0,
        CTRL_MEM_TO_REG = 1,
        CTRL_MEM_READ   = 2,
        CTRL_MEM_WRITE  = 3,
        CTRL_CSR_WRITE  = 4,
        CTRL_BRANCH     = 5,
        CTRL_JUMP       = 6,
        CTRL_ALU_SRC    = 7
    } pipe_ctrl_bit_e;

    localparam logic [PIPE_CTRL_W-1:0] BUBBLE_CTRL = '0;

endpackage
`default_nettype wire

// File: rtl/pipe_bridge_slot.sv
`default_nettype none
// ============================================================================
// Module : pipe_bridge_slot
// Brief  : One {valid,data,ctrl} pipeline entry. Clear wins over load and
//          zeroes ctrl while keeping data, so an empty slot is a clean bubble.
// Rev    : 1.0 - initial release
// ============================================================================
module pipe_bridge_slot
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = PIPE_DATA_W,
    parameter int                CTRL_W   = PIPE_CTRL_W,
    parameter logic [DATA_W-1:0] DATA_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= DATA_RST;
            r_ctrl  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_ctrl  <= i_ctrl;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ctrl  = r_ctrl;

endmodule
`default_nettype wire

// File: rtl/pipe_bridge_reg.sv
`default_nettype none
// ============================================================================
// Module : pipe_bridge_reg
// Brief  : Generic valid/ready inter-stage pipeline register with flush.
//          Define PIPE_BRIDGE_SKID_EN for a main+skid buffer whose in_ready
//          has no combinational path from out_ready.
// Rev    : 1.0 - initial release
// ============================================================================
module pipe_bridge_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = PIPE_DATA_W,
    parameter int                CTRL_W   = PIPE_CTRL_W,
    parameter logic [DATA_W-1:0] DATA_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
);

    logic              w_accept;
    logic              w_main_valid;
    logic              w_main_load;
    logic              w_main_clear;
    logic [DATA_W-1:0] w_main_din;
    logic [CTRL_W-1:0] w_main_cin;
    logic [DATA_W-1:0] w_main_data;
    logic [CTRL_W-1:0] w_main_ctrl;

`ifdef PIPE_BRIDGE_SKID_EN
    logic              w_skid_valid;
    logic              w_skid_load;
    logic              w_skid_clear;
    logic [DATA_W-1:0] w_skid_data;
    logic [CTRL_W-1:0] w_skid_ctrl;

    assign in_ready = ~w_skid_valid & ~flush;
    assign w_accept = in_valid & in_ready;

    // Priority: flush > refill from skid > load from input > drain.
    always_comb begin
        w_main_load  = 1'b0;
        w_main_clear = 1'b0;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        w_main_din   = in_data;
        w_main_cin   = in_ctrl;
        if (flush) begin
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else if (w_skid_valid) begin
            if (out_ready) begin
                w_main_load  = 1'b1;
                w_main_din   = w_skid_data;
                w_main_cin   = w_skid_ctrl;
                w_skid_clear = 1'b1;
            end
        end else if (w_accept) begin
            if (w_main_valid && !out_ready) begin
                w_skid_load = 1'b1;
            end else begin
                w_main_load = 1'b1;
            end
        end else if (w_main_valid && out_ready) begin
            w_main_clear = 1'b1;
        end
    end

    pipe_bridge_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .DATA_RST (DATA_RST)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (in_data),
        .i_ctrl  (in_ctrl),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data),
        .o_ctrl  (w_skid_ctrl)
    );
`else
    assign in_ready     = (~w_main_valid | out_ready) & ~flush;
    assign w_accept     = in_valid & in_ready;
    assign w_main_load  = w_accept;
    assign w_main_clear = flush | (w_main_valid & out_ready & ~w_accept);
    assign w_main_din   = in_data;
    assign w_main_cin   = in_ctrl;
`endif

    pipe_bridge_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .DATA_RST (DATA_RST)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_data  (w_main_din),
        .i_ctrl  (w_main_cin),
        .o_valid (w_main_valid),
        .o_data  (w_main_data),
        .o_ctrl  (w_main_ctrl)
    );

    assign out_valid = w_main_valid;
    assign out_data  = w_main_data;
    assign out_ctrl  = w_main_ctrl;

    a_bubble_ctrl_zero : assert property (
        @(posedge clk) disable iff (!rst) !out_valid |-> (out_ctrl == '0)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipe_bridge_reg.sv
`default_nettype none
// ============================================================================
// Module : tb_pipe_bridge_reg
// Brief  : Scoreboard bench for pipe_bridge_reg, with or without
//          PIPE_BRIDGE_SKID_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pipe_bridge_reg;

    localparam logic [31:0] c_data_rst = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [7:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_ctrl;

    int checks   = 0;
    int failures = 0;

    logic [39:0] sb[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [7:0]  prev_ctrl;

    always #5 clk = ~clk;

    pipe_bridge_reg #(
        .DATA_W   (32),
        .CTRL_W   (8),
        .DATA_RST (c_data_rst)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
    );

    function automatic logic [7:0] ctl(input logic [31:0] d);
        return (d[7:0] * 8'd3) | 8'h80;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic v, input logic [31:0] d, input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = ctl(d);
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    // Expected beats enter the scoreboard when the upstream handshake completes.
    always @(negedge clk) begin
        if (rst && in_valid && in_ready && !flush)
            sb.push_back({in_data, in_ctrl});
    end

    // Monitor: pops on every downstream handshake, enforces bubble and hold rules.
    always @(negedge clk) begin
        logic [39:0] exp_beat;
        if (!rst) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (!out_valid)
                chk("bubble_ctrl", out_ctrl, 8'h00);
            if (prev_stall)
                chk("stall_hold", {out_valid, out_data, out_ctrl}, {1'b1, prev_data, prev_ctrl});
            if (flush)
                chk("flush_in_ready", in_ready, 1'b0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_extra_beat actual=%0h expected=none at %0t", out_data, $time);
                end else begin
                    exp_beat = sb.pop_front();
                    chk("sb_beat", {out_data, out_ctrl}, exp_beat);
                end
            end
            if (flush)
                sb.delete();
            prev_stall = out_valid && !out_ready && !flush;
            prev_data  = out_data;
            prev_ctrl  = out_ctrl;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          nxt;
        int          stall_acc;
        logic        hs;
        logic        stall;

        // Reset with a live upstream beat that must be ignored
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_ctrl = ctl(32'hDEAD_BEEF);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, c_data_rst);
        chk("rst_out_ctrl", out_ctrl, 8'h00);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Streaming 1..16 at one beat per cycle, 1-cycle latency
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, i, 1'b1, 1'b0);
            chk("stream_out", {out_valid, out_data}, {1'b1, i[31:0]});
        end
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        chk("stream_end", out_valid, 1'b0);

        // Backpressure: out_ready low for 3 cycles while upstream keeps offering
        nxt = 20;
        stall_acc = 0;
        for (int c = 0; c < 10; c++) begin
            stall     = (c >= 3 && c < 6);
            in_valid  = 1'b1;
            in_data   = nxt;
            in_ctrl   = ctl(nxt);
            out_ready = !stall;
            flush     = 1'b0;
            @(negedge clk);
            hs = in_ready;
            if (stall) begin
                chk("bp_hold_data", out_data, 32'd22);
                if (hs) stall_acc++;
            end
`ifdef PIPE_BRIDGE_SKID_EN
            if (c == 3) chk("bp_ready_c3", in_ready, 1'b1);
            if (c == 4) chk("bp_ready_c4", in_ready, 1'b0);
`else
            if (c == 3) chk("bp_ready_c3", in_ready, 1'b0);
`endif
            @(posedge clk);
            #1;
            if (hs) nxt++;
        end
`ifdef PIPE_BRIDGE_SKID_EN
        chk("bp_absorbed", stall_acc, 1);
`else
        chk("bp_absorbed", stall_acc, 0);
`endif
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_drained", sb.size(), 0);
        chk("bp_idle", out_valid, 1'b0);

        // Flush with main=5 (and skid=6 when present), offering 7 during flush
        cyc(1'b1, 32'd5, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 32'd6; in_ctrl = ctl(32'd6); out_ready = 1'b0; flush = 1'b0;
        @(negedge clk);
`ifdef PIPE_BRIDGE_SKID_EN
        chk("fl_skid_accept", in_ready, 1'b1);
`else
        chk("fl_skid_accept", in_ready, 1'b0);
`endif
        @(posedge clk);
        #1;
        in_valid = 1'b1; in_data = 32'd7; in_ctrl = ctl(32'd7); out_ready = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("fl_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("fl_valid", out_valid, 1'b0);
        chk("fl_ctrl", out_ctrl, 8'h00);
        chk("fl_data_kept", out_data, 32'd5);
        in_valid = 1'b1; in_data = 32'd8; in_ctrl = ctl(32'd8); out_ready = 1'b1; flush = 1'b0;
        @(negedge clk);
        chk("fl_skid_empty", in_ready, 1'b1);
        @(posedge clk);
        #1;
        chk("fl_next_beat", {out_valid, out_data}, {1'b1, 32'd8});

        // Simultaneous drain and accept keeps out_valid high
        cyc(1'b1, 32'd30, 1'b1, 1'b0);
        in_valid = 1'b1; in_data = 32'd9; in_ctrl = ctl(32'd9); out_ready = 1'b1;
        @(negedge clk);
        chk("da_ready", {out_valid, in_ready}, 2'b11);
        @(posedge clk);
        #1;
        chk("da_out", {out_valid, out_data, out_ctrl}, {1'b1, 32'd9, ctl(32'd9)});
        cyc(1'b0, 32'd0, 1'b1, 1'b0);

        // Asynchronous reset while a beat is held
        cyc(1'b1, 32'd40, 1'b0, 1'b0);
        chk("ar_loaded", {out_valid, out_data}, {1'b1, 32'd40});
        rst = 1'b0;
        #1;
        chk("ar_valid", out_valid, 1'b0);
        chk("ar_data", out_data, c_data_rst);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_after", out_valid, 1'b0);

        // Random traffic with ~5% flush
        nxt = 1000;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = nxt;
            in_ctrl   = ctl(nxt);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 99) < 5);
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (hs) nxt++;
        end
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rnd_drained", sb.size(), 0);
        chk("rnd_idle", out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
